// File: rtl/pattern_loader_if.sv
// -----------------------------------------------------------------------------
// pattern_loader_if
// Host-side bus of the pattern loader: frame control, byte write channel
// (valid/ready) and readback channel.
//   start    : single-cycle request to begin a frame        (host -> loader)
//   busy     : frame in progress, up to and including done  (loader -> host)
//   done     : one-cycle pulse, last bit of the frame sent  (loader -> host)
//   wr_data  : pattern byte                                  (host -> loader)
//   wr_valid : wr_data valid                                 (host -> loader)
//   wr_ready : loader accepts a byte this cycle              (loader -> host)
//   rd_data  : byte shifted out of the buffer                (loader -> host)
//   rd_valid : one-cycle pulse, rd_data valid                (loader -> host)
// -----------------------------------------------------------------------------
interface pattern_loader_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    output start, wr_data, wr_valid,
    input  busy, done, wr_ready, rd_data, rd_valid
  );

  modport slave (
    input  start, wr_data, wr_valid,
    output busy, done, wr_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/pattern_loader.sv
// -----------------------------------------------------------------------------
// pattern_loader
// Fills the downstream 8-bit-wide serial pattern shift buffer. Bytes arrive
// from the host over a valid/ready channel and are serialised MSB-first onto
// sclk/ssel/sin. A frame is exactly BUFSIZE bytes; the first byte sent ends
// up in buffer entry BUFSIZE-1, the last in entry 0.
//
// Optional feature (macro PATTERN_LOADER_READBACK_EN): bits leaving the
// buffer on sout are captured MSB-first and returned as rd_data/rd_valid, so
// the old buffer contents read back while the new ones load. Without the
// macro sout is ignored and rd_data/rd_valid are tied to 0.
//
// Parameters:
//   BUFSIZE : bytes per frame (downstream buffer depth)
//   CLK_DIV : sclk half-period in clk cycles, 1..255
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   host  : host bus (pattern_loader_if.slave)
//   sclk  : serial clock to the buffer (registered)
//   ssel  : serial select to the buffer (registered)
//   sin   : serial data to the buffer (registered)
//   sout  : serial data returned from the buffer (its top bit)
// -----------------------------------------------------------------------------
module pattern_loader #(
  parameter int BUFSIZE = 27,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pattern_loader_if.slave  host,
  output logic             sclk,
  output logic             ssel,
  output logic             sin,
  input  logic             sout
);

  localparam int              BYTE_W    = $clog2(BUFSIZE + 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BUFSIZE - 1);
  localparam logic [7:0]      DIV_LAST  = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_BIT_LO,
    S_BIT_HI,
    S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [BYTE_W-1:0]   r_byte_cnt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_div_cnt;
  // Holds only the bits still to be sent after the one currently on sin;
  // the bit on sin lives in r_sin, so no extra MSB copy is kept.
  logic [6:0]          r_shift;
  logic                r_sclk;
  logic                r_ssel;
  logic                r_sin;

  logic                w_phase_end;
  logic                w_byte_last;
  logic                w_frame_last;

  assign w_phase_end  = (r_div_cnt == DIV_LAST);
  assign w_byte_last  = (r_bit_cnt == 3'd7);
  assign w_frame_last = (r_byte_cnt == LAST_BYTE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: every clocked assignment is non-blocking so all registers see
      // the pre-edge values of each other, independent of statement order.
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default comes first so every path assigns w_next_state and
    // no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (host.start)    w_next_state = S_WAIT_BYTE;
      S_WAIT_BYTE: if (host.wr_valid) w_next_state = S_BIT_LO;
      S_BIT_LO:    if (w_phase_end)   w_next_state = S_BIT_HI;
      S_BIT_HI: begin
        if (w_phase_end) begin
          if (!w_byte_last)      w_next_state = S_BIT_LO;
          else if (w_frame_last) w_next_state = S_FINISH;
          else                   w_next_state = S_WAIT_BYTE;
        end
      end
      S_FINISH:    w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered serial outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
      r_shift    <= '0;
      r_sclk     <= 1'b0;
      r_ssel     <= 1'b0;
      r_sin      <= 1'b0;
    end else begin
      // Serial lines are decoded from the next state so they line up with the
      // state they belong to; sclk and sin/ssel therefore never move apart
      // while sclk is high.
      r_sclk <= (w_next_state == S_BIT_HI);
      r_ssel <= (w_next_state inside {S_WAIT_BYTE, S_BIT_LO, S_BIT_HI});

      // Phase timer restarts at every phase boundary and outside the bit phases.
      if ((r_state inside {S_BIT_LO, S_BIT_HI}) && !w_phase_end)
        r_div_cnt <= r_div_cnt + 8'd1;
      else
        r_div_cnt <= '0;

      case (r_state)
        S_IDLE: begin
          if (host.start) r_byte_cnt <= '0;
        end
        S_WAIT_BYTE: begin
          if (host.wr_valid) begin
            r_sin     <= host.wr_data[7];
            r_shift   <= host.wr_data[6:0];
            r_bit_cnt <= '0;
          end
        end
        S_BIT_HI: begin
          if (w_phase_end) begin
            r_shift   <= {r_shift[5:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_last)
              r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
            else
              r_sin <= r_shift[6];
          end
        end
        default: ;
      endcase
    end
  end

  assign sclk          = r_sclk;
  assign ssel          = r_ssel;
  assign sin           = r_sin;
  assign host.busy     = (r_state != S_IDLE);
  assign host.done     = (r_state == S_FINISH);
  assign host.wr_ready = (r_state == S_WAIT_BYTE);

  // ---------------------------------------------------------------------------
  // Readback capture
  // ---------------------------------------------------------------------------
`ifdef PATTERN_LOADER_READBACK_EN
  logic [7:0] r_cap;
  logic [7:0] r_rd_data;
  logic       r_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      // sout is sampled just before the sclk rise that would replace it.
      if (r_state == S_BIT_LO && w_phase_end)
        r_cap <= {r_cap[6:0], sout};
      if (r_state == S_BIT_HI && w_phase_end && w_byte_last) begin
        r_rd_data  <= r_cap;
        r_rd_valid <= 1'b1;
      end
    end
  end

  assign host.rd_data  = r_rd_data;
  assign host.rd_valid = r_rd_valid;
`else
  logic w_unused_sout;
  assign w_unused_sout = sout;

  assign host.rd_data  = '0;
  assign host.rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_loader.sv
// -----------------------------------------------------------------------------
// tb_pattern_loader
// Directed bench for pattern_loader. DUT A: BUFSIZE=4, CLK_DIV=1.
// DUT B: BUFSIZE=1, CLK_DIV=3. Each DUT drives a behavioural model of the
// downstream shift buffer (shifts sin in on sclk rise, returns its top bit).
// -----------------------------------------------------------------------------
module tb_pattern_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  pattern_loader_if a_if ();
  pattern_loader_if b_if ();

  logic a_sclk, a_ssel, a_sin, a_sout;
  logic b_sclk, b_ssel, b_sin, b_sout;

  pattern_loader #(.BUFSIZE(4), .CLK_DIV(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (a_if),
    .sclk  (a_sclk),
    .ssel  (a_ssel),
    .sin   (a_sin),
    .sout  (a_sout)
  );

  pattern_loader #(.BUFSIZE(1), .CLK_DIV(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (b_if),
    .sclk  (b_sclk),
    .ssel  (b_ssel),
    .sin   (b_sin),
    .sout  (b_sout)
  );

  // ---------------------------------------------------------------------------
  // Downstream buffer models; entry k of A is m_buf_a[8k+7:8k]
  // ---------------------------------------------------------------------------
  logic [31:0] m_buf_a;
  logic        load_a;
  logic [31:0] load_val_a;
  always @(posedge a_sclk or posedge load_a) begin
    if (load_a) m_buf_a <= load_val_a;
    else        m_buf_a <= {m_buf_a[30:0], a_sin};
  end
  assign a_sout = m_buf_a[31];

  logic [7:0] m_buf_b = 8'h00;
  always @(posedge b_sclk) m_buf_b <= {m_buf_b[6:0], b_sin};
  assign b_sout = m_buf_b[7];

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  int          rise_a     = 0;
  logic [31:0] sin_seq_a  = '0;
  always @(posedge a_sclk) begin
    rise_a    <= rise_a + 1;
    sin_seq_a <= {sin_seq_a[30:0], a_sin};
  end

  int          done_a_cnt = 0;
  int          rd_a_cnt   = 0;
  logic [31:0] rd_seq_a   = '0;
  int          viol       = 0;
  logic        p_sin_a = 1'b0, p_ssel_a = 1'b0, p_sin_b = 1'b0, p_ssel_b = 1'b0;
  always @(negedge clk) begin
    if (a_if.done === 1'b1) done_a_cnt <= done_a_cnt + 1;
    if (a_if.rd_valid === 1'b1) begin
      rd_a_cnt <= rd_a_cnt + 1;
      rd_seq_a <= {rd_seq_a[23:0], a_if.rd_data};
    end
    // sin/ssel must not move at or during an sclk-high phase
    if ((a_sclk === 1'b1 && (a_sin !== p_sin_a || a_ssel !== p_ssel_a)) ||
        (b_sclk === 1'b1 && (b_sin !== p_sin_b || b_ssel !== p_ssel_b)))
      viol <= viol + 1;
    p_sin_a  <= a_sin;
    p_ssel_a <= a_ssel;
    p_sin_b  <= b_sin;
    p_ssel_b <= b_ssel;
  end

  // ---------------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
  endtask

  // Presents a byte and returns one cycle after it has been accepted.
  task automatic send_a(input logic [7:0] b);
    int n;
    n = 0;
    a_if.wr_data  = b;
    a_if.wr_valid = 1'b1;
    while (a_if.wr_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("a_wr_ready_seen", 64'(a_if.wr_ready), 64'(1));
    tick();
    a_if.wr_valid = 1'b0;
  endtask

  task automatic wait_done_a();
    int n;
    n = 0;
    while (a_if.done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("a_done_seen", 64'(a_if.done), 64'(1));
    check("a_busy_in_done_cycle", 64'(a_if.busy), 64'(1));
    tick();
    check("a_busy_done_after", 64'({a_if.busy, a_if.done}), 64'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int          snap_rise, snap_done, snap_rd, n_wait;
  logic        ok;
  logic [47:0] sclk_pat, sin_pat, exp_sclk, exp_sin;

  initial begin
    rst_n         = 1'b0;
    a_if.start    = 1'b0;
    a_if.wr_data  = '0;
    a_if.wr_valid = 1'b0;
    b_if.start    = 1'b0;
    b_if.wr_data  = '0;
    b_if.wr_valid = 1'b0;
    load_val_a    = '0;
    load_a        = 1'b0;
    #1 load_a = 1'b1;
    #1 load_a = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_state_a", 64'({a_sclk, a_ssel, a_sin, a_if.busy, a_if.done,
                                a_if.wr_ready, a_if.rd_valid, a_if.rd_data}), 64'(0));
    check("reset_state_b", 64'({b_sclk, b_ssel, b_sin, b_if.busy, b_if.done,
                                b_if.wr_ready, b_if.rd_valid, b_if.rd_data}), 64'(0));
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of BIT_HI
    start_a();
    send_a(8'hFF);
    n_wait = 0;
    while (a_sclk !== 1'b1 && n_wait < 50) begin
      tick();
      n_wait++;
    end
    check("a_sclk_high_before_reset", 64'(a_sclk), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'({a_sclk, a_ssel, a_sin, a_if.busy, a_if.done,
                                      a_if.wr_ready, a_if.rd_valid, a_if.rd_data}), 64'(0));
    a_if.start = 1'b1;
    @(posedge clk);
    #1 a_if.start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("start_during_reset_ignored", 64'({a_if.busy, a_if.wr_ready}), 64'(0));
    start_a();
    check("wait_byte_after_start", 64'({a_if.busy, a_if.wr_ready, a_ssel, a_sclk}), 64'(4'b1110));

    // Frame A1 B2 C3 D4, no stalls
    snap_rise = rise_a;
    snap_done = done_a_cnt;
    send_a(8'hA1);
    check("a_first_bit_sin", 64'({a_sclk, a_sin}), 64'(2'b01));
    tick();
    check("a_first_rise_t_plus_2", 64'(a_sclk), 64'(1));
    send_a(8'hB2);
    send_a(8'hC3);
    send_a(8'hD4);
    wait_done_a();
    check("frame1_sclk_rises", 64'(rise_a - snap_rise), 64'(32));
    check("frame1_sin_sequence", 64'(sin_seq_a), 64'(32'hA1B2C3D4));
    check("frame1_buffer", 64'(m_buf_a), 64'(32'hA1B2C3D4));
    check("frame1_done_pulses", 64'(done_a_cnt - snap_done), 64'(1));

    // Frame with a 10-cycle host stall and a start pulse while busy
    snap_rise = rise_a;
    snap_done = done_a_cnt;
    start_a();
    send_a(8'h5A);
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    send_a(8'h3C);
    n_wait = 0;
    while (a_if.wr_ready !== 1'b1 && n_wait < 200) begin
      tick();
      n_wait++;
    end
    check("stall_reached_wait_byte", 64'(a_if.wr_ready), 64'(1));
    snap_rd = rise_a;
    ok = 1'b1;
    repeat (10) begin
      ok = ok & (a_sclk === 1'b0) & (a_ssel === 1'b1) & (a_if.wr_ready === 1'b1);
      tick();
    end
    check("stall_lines_idle", 64'(ok), 64'(1));
    check("stall_no_shift", 64'(rise_a - snap_rd), 64'(0));
    send_a(8'hE7);
    send_a(8'h18);
    wait_done_a();
    check("frame2_sclk_rises", 64'(rise_a - snap_rise), 64'(32));
    check("frame2_buffer", 64'(m_buf_a), 64'(32'h5A3CE718));
    check("frame2_done_pulses", 64'(done_a_cnt - snap_done), 64'(1));

    // wr_valid in IDLE is ignored
    snap_rise = rise_a;
    ok = 1'b1;
    a_if.wr_data  = 8'h99;
    a_if.wr_valid = 1'b1;
    repeat (5) begin
      ok = ok & (a_if.wr_ready === 1'b0) & (a_if.busy === 1'b0);
      tick();
    end
    a_if.wr_valid = 1'b0;
    check("idle_ignores_wr_valid", 64'(ok), 64'(1));
    check("idle_no_shift", 64'(rise_a - snap_rise), 64'(0));

    // Readback frame: buffer preloaded with entries 0..3 = 11,22,33,44
    load_val_a = 32'h44332211;
    load_a     = 1'b1;
    #1 load_a  = 1'b0;
    snap_rd = rd_a_cnt;
    start_a();
    send_a(8'h55);
    send_a(8'h66);
    send_a(8'h77);
    send_a(8'h88);
    wait_done_a();
    check("frame3_buffer", 64'(m_buf_a), 64'(32'h55667788));
`ifdef PATTERN_LOADER_READBACK_EN
    check("readback_pulses", 64'(rd_a_cnt - snap_rd), 64'(4));
    check("readback_sequence", 64'(rd_seq_a), 64'(32'h44332211));
    check("readback_hold", 64'(a_if.rd_data), 64'(8'h11));
`else
    check("readback_never_valid", 64'(rd_a_cnt), 64'(0));
    check("readback_data_zero", 64'(a_if.rd_data), 64'(0));
`endif

    // DUT B: CLK_DIV=3, single byte 0x80
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0;
    check("b_wr_ready_after_start", 64'({b_if.wr_ready, b_ssel}), 64'(2'b11));
    b_if.wr_data  = 8'h80;
    b_if.wr_valid = 1'b1;
    tick();
    b_if.wr_valid = 1'b0;
    for (int i = 0; i < 48; i++) begin
      sclk_pat[i] = b_sclk;
      sin_pat[i]  = b_sin;
      exp_sclk[i] = ((i % 6) >= 3);
      exp_sin[i]  = (i < 6);
      tick();
    end
    check("b_sclk_waveform", 64'(sclk_pat), 64'(exp_sclk));
    check("b_sin_waveform", 64'(sin_pat), 64'(exp_sin));
    check("b_finish_cycle", 64'({b_if.done, b_if.busy, b_ssel, b_sclk}), 64'(4'b1100));
    tick();
    check("b_idle_after_done", 64'({b_if.done, b_if.busy}), 64'(0));
    check("b_buffer", 64'(m_buf_b), 64'(8'h80));

    check("ssel_sin_stable_while_sclk_high", 64'(viol), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_loader.md
Name: pattern_loader

Overview:
- Front-end stage that fills the 8-bit-wide serial pattern shift buffer.
- Takes bytes from a host over a valid/ready interface and serialises each byte MSB-first onto sclk/ssel/sin.
- Optionally captures the bits leaving the buffer on sout, so the old contents read back while new ones load.
- One frame is exactly BUFSIZE bytes.

Parameters:
- BUFSIZE, 27, number of bytes in the downstream pattern buffer (frame length).
- CLK_DIV, 2, sclk half-period in clk cycles (legal range 1..255).

Ports:
- clk, input, 1, system clock; all state on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to begin a frame.
- busy, output, 1, high from accepted start until the done cycle inclusive.
- done, output, 1, one-cycle pulse when the last bit of the frame has been clocked.
- wr_data, input, 8, pattern byte from the host.
- wr_valid, input, 1, wr_data valid.
- wr_ready, output, 1, loader accepts a byte this cycle.
- rd_data, output, 8, byte shifted out of the buffer (readback).
- rd_valid, output, 1, one-cycle pulse; rd_data is valid.
- sclk, output, 1, serial clock to the buffer (registered).
- ssel, output, 1, serial select to the buffer (registered).
- sin, output, 1, serial data to the buffer (registered).
- sout, input, 1, serial data returned from the buffer (its top bit).

Behaviour:
- Reset (asynchronous, active-low) drives all outputs to 0: sclk, ssel, sin, busy, done, wr_ready, rd_valid, rd_data.
- Reset also sets the FSM to IDLE and clears byte_cnt, bit_cnt and div_cnt.
- Reset mid-frame abandons the frame. The buffer is left partially shifted, and the host must issue a full new frame.
- FSM states: IDLE, WAIT_BYTE, BIT_LO, BIT_HI, FINISH.
- IDLE:
  - ssel=0, sclk=0.
  - start=1 -> WAIT_BYTE, with byte_cnt=0, ssel=1, busy=1.
  - wr_valid is ignored in IDLE (wr_ready=0).
- WAIT_BYTE:
  - wr_ready=1, sclk held 0, ssel held 1.
  - On wr_valid&wr_ready: latch the byte into the shift register, set bit_cnt=0 -> BIT_LO.
  - Host stalls are unlimited; the buffer does not shift while sclk is idle.
- BIT_LO:
  - Lasts CLK_DIV cycles, sclk=0.
  - sin = current MSB of the shift register, driven in the first cycle of the phase.
  - Last cycle: sout is sampled into the readback register -> BIT_HI.
- BIT_HI:
  - Lasts CLK_DIV cycles, sclk=1; the buffer shifts on the sclk rising edge.
  - Last cycle: shift register left by 1, bit_cnt++.
  - If bit_cnt was 7: byte_cnt++, then -> FINISH if byte_cnt reaches BUFSIZE, else -> WAIT_BYTE. Otherwise -> BIT_LO.
- sin and ssel change only while sclk=0, so they are stable at least CLK_DIV cycles before each sclk rise.
- Timing: byte accepted at cycle t -> sin=MSB at t+1 -> first sclk rise at t+1+CLK_DIV. One byte takes 16*CLK_DIV cycles plus 1 cycle in WAIT_BYTE.
- FINISH: lasts 1 cycle, done=1, sclk=0, ssel=0 -> IDLE. busy drops the cycle after done.
- Byte ordering:
  - Bytes are consumed in descending buffer index: the first byte sent lands in buffer entry BUFSIZE-1, the last byte in entry 0.
  - After a full frame, entry k holds the (BUFSIZE-k)th byte sent.
- start while busy is ignored. start coincident with reset has no effect.
- Only the low log2 bits needed for the counters are used; byte_cnt is wide enough for BUFSIZE with no wrap inside a frame.

Optional Feature:
- Macro: PATTERN_LOADER_READBACK_EN.
- With the macro defined:
  - sout sampled bits are shifted MSB-first into an 8-bit capture register.
  - After the 8th sample of each byte, rd_data = captured byte and rd_valid pulses 1 cycle (in the cycle after the byte's last BIT_HI).
  - The nth rd byte equals the old contents of entry BUFSIZE-n.
  - rd_data holds its value until the next byte.
- Without the macro:
  - sout is unused, the capture logic is absent, and rd_data=0 and rd_valid=0 permanently.

Test Plan:
- Reset mid-BIT_HI with BUFSIZE=4, CLK_DIV=1 -> all outputs 0 immediately (asynchronous); next start -> clean frame, wr_ready=1 one cycle after start.
- Frame 0xA1,0xB2,0xC3,0xD4 with BUFSIZE=4, CLK_DIV=1, no stalls -> exactly 32 sclk rises, sin sequence = bits MSB-first, model buffer = {D4,C3,B2,A1} at index 0..3; done pulses once and busy falls the next cycle.
- CLK_DIV=3, single byte 0x80 -> sclk high/low 3 cycles each; sin=1 for the first bit only; first sclk rise 4 cycles after acceptance.
- wr_valid deasserted for 10 cycles between bytes 2 and 3 -> sclk stays 0, ssel stays 1, no extra shifts; final buffer still correct.
- start pulsed while busy, and wr_valid asserted in IDLE -> no effect: wr_ready=0 in IDLE, and byte_cnt is unchanged.
- Readback (macro on): preload the model buffer {11,22,33,44}, load {55,66,77,88} -> rd_data sequence 44,33,22,11, four rd_valid pulses; with the macro off, rd_valid never asserts.
